// File: rtl/quad_decoder.sv
// Quadrature decoder: per-channel synchronisers, a run-length glitch filter on the
// synchronised pair, step/error decode, and registered up/down/count/dir/err outputs.
module quad_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       qa,
    input  logic       qb,
    input  logic       err_clr,
    output logic       up,
    output logic       down,
    output logic [2:0] count,
    output logic       dir,
    output logic       err
);

    localparam int unsigned RUN_W = 4;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned POS_W = 2;

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             pair_c;

    logic [1:0]       cand;
    logic [1:0]       acc;
    logic             ref_valid;
    logic [RUN_W-1:0] run;

    logic             fwd_q;
    logic             rev_q;
    logic             bad_q;

    logic [RUN_W-1:0] run_inc_c;
    logic             hold_c;
    logic             accept_c;
    logic [POS_W-1:0] pos_new_c;
    logic [POS_W-1:0] pos_old_c;
    logic [POS_W-1:0] delta_c;

    // Independent synchroniser chain per channel
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], qa};
            sync_b <= {sync_b[SYNC_STAGES-2:0], qb};
        end
    end

    assign pair_c = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    // Filter run length and Gray-to-position step classification
    always_comb begin
        run_inc_c = RUN_W'(1);
        if (pair_c == cand) begin
            run_inc_c = run + RUN_W'(1);
        end
        hold_c    = ref_valid && (pair_c == acc);
        accept_c  = !hold_c && (run_inc_c >= RUN_W'(FILTER_LEN));
        pos_new_c = {pair_c[1], pair_c[1] ^ pair_c[0]};
        pos_old_c = {acc[1], acc[1] ^ acc[0]};
        delta_c   = pos_new_c - pos_old_c;
    end

    // Accepted-state register; a step event is flagged on the accepting edge
    always_ff @(posedge clk) begin
        if (rst) begin
            cand      <= '0;
            acc       <= '0;
            ref_valid <= 1'b0;
            run       <= '0;
            fwd_q     <= 1'b0;
            rev_q     <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            cand  <= pair_c;
            fwd_q <= 1'b0;
            rev_q <= 1'b0;
            bad_q <= 1'b0;
            if (hold_c) begin
                run <= '0;
            end else if (accept_c) begin
                run       <= '0;
                acc       <= pair_c;
                ref_valid <= 1'b1;
                fwd_q     <= ref_valid && (delta_c == POS_W'(1));
                rev_q     <= ref_valid && (delta_c == POS_W'(3));
                bad_q     <= ref_valid && (delta_c == POS_W'(2));
            end else begin
                run <= run_inc_c;
            end
        end
    end

    // Output stage, one edge after the accepted-state update; error set beats clear
    always_ff @(posedge clk) begin
        if (rst) begin
            up    <= 1'b0;
            down  <= 1'b0;
            count <= '0;
            dir   <= 1'b0;
            err   <= 1'b0;
        end else begin
            up   <= fwd_q;
            down <= rev_q;
            if (fwd_q) begin
                count <= count + CNT_W'(1);
                dir   <= 1'b1;
            end else if (rev_q) begin
                count <= count - CNT_W'(1);
                dir   <= 1'b0;
            end
            err <= bad_q || (err && !err_clr);
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder at default parameters.
module tb_quad_decoder;

    localparam int unsigned LAT  = 6;
    localparam int unsigned HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       qa = 1'b0;
    logic       qb = 1'b0;
    logic       err_clr = 1'b0;
    logic       up;
    logic       down;
    logic [2:0] count;
    logic       dir;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    quad_decoder dut (
        .clk(clk), .rst(rst), .qa(qa), .qb(qb), .err_clr(err_clr),
        .up(up), .down(down), .count(count), .dir(dir), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a new pair and watch HOLD edges; a pulse is expected only at edge LAT
    task automatic apply(input logic [1:0] ab, input bit exp_up, input bit exp_dn);
        {qa, qb} = ab;
        for (int i = 1; i <= int'(HOLD); i++) begin
            tick();
            chk("up",   int'(up),   int'(exp_up && (i == int'(LAT))));
            chk("down", int'(down), int'(exp_dn && (i == int'(LAT))));
        end
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("quiet_up",   int'(up),   0);
            chk("quiet_down", int'(down), 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {qa, qb} = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset values and reference load on 00
        do_reset();
        chk("rst_count", int'(count), 0);
        chk("rst_err",   int'(err),   0);
        chk("rst_dir",   int'(dir),   0);
        quiet(10);
        chk("ref_count", int'(count), 0);
        chk("ref_err",   int'(err),   0);

        // Four forward steps
        apply(2'b01, 1, 0);
        apply(2'b11, 1, 0);
        apply(2'b10, 1, 0);
        apply(2'b00, 1, 0);
        chk("fwd_count", int'(count), 4);
        chk("fwd_dir",   int'(dir),   1);

        // Reverse wrap 0->7, then eight forward steps wrap back to 7
        do_reset();
        quiet(10);
        apply(2'b10, 0, 1);
        chk("rev_count", int'(count), 7);
        chk("rev_dir",   int'(dir),   0);
        for (int k = 0; k < 2; k++) begin
            apply(2'b00, 1, 0);
            apply(2'b01, 1, 0);
            apply(2'b11, 1, 0);
            apply(2'b10, 1, 0);
        end
        chk("wrap_count", int'(count), 7);
        chk("wrap_dir",   int'(dir),   1);

        // Two-cycle glitch on qb is rejected
        {qa, qb} = 2'b11;
        tick();
        tick();
        {qa, qb} = 2'b10;
        quiet(10);
        chk("glitch_count", int'(count), 7);

        // Double-bit jump sets err, no count change; then clear
        apply(2'b01, 0, 0);
        chk("jump_err",   int'(err),   1);
        chk("jump_count", int'(count), 7);
        chk("jump_dir",   int'(dir),   1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_err", int'(err), 0);

        // err_clr coinciding with a new error: set wins
        {qa, qb} = 2'b10;
        for (int i = 1; i < int'(LAT); i++) tick();
        chk("pre_set_err", int'(err), 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("setwins_err", int'(err), 1);
        tick();
        tick();
        chk("sticky_err",   int'(err),   1);
        chk("sticky_count", int'(count), 7);

        // Counting continues while err is set: 7 + 6 = 5 mod 8
        apply(2'b00, 1, 0);
        apply(2'b01, 1, 0);
        apply(2'b11, 1, 0);
        apply(2'b10, 1, 0);
        apply(2'b00, 1, 0);
        apply(2'b01, 1, 0);
        chk("pre_rst_count", int'(count), 5);
        chk("pre_rst_err",   int'(err),   1);

        // Reset in the middle of a filter run
        {qa, qb} = 2'b11;
        tick();
        tick();
        rst = 1'b1;
        err_clr = 1'b1;
        tick();
        rst = 1'b0;
        err_clr = 1'b0;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_err",   int'(err),   0);
        chk("mid_rst_up",    int'(up),    0);
        quiet(12);
        chk("reref_count", int'(count), 0);
        chk("reref_err",   int'(err),   0);

        // Reference is now 11: 11->10 is forward
        apply(2'b10, 1, 0);
        chk("post_count", int'(count), 1);
        chk("post_dir",   int'(dir),   1);
        chk("post_err",   int'(err),   0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog keeps the run bounded
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
